cache_block_responder: RTL

//  Memory-side responder for the cache miss/writeback command+buffer interface. Accepts single-word
//  or block requests from a cache controller, buffers write words into a FIFO and drains them to a

---
 rtl/cache_block_responder.sv | 120 ++++++++++++
 1 files changed

// File: rtl/cache_block_responder.sv
// cache_block_responder: buffers cache block/word transfers between a cache and backing memory
module cache_block_responder #(
    parameter int BW_WORD_ADDR = 24,
    parameter int BW_BLOCK     = 4,
    parameter int FIFO_DEPTH   = 16
) (
    input  logic                    clock_i,
    input  logic                    reset_i,
    input  logic                    req_i,
    input  logic                    req_block_i,
    input  logic                    rw_i,
    input  logic [BW_WORD_ADDR-1:0] add_i,
    input  logic                    write_i,
    input  logic                    read_i,
    input  logic [31:0]             data_i,
    output logic                    ready_req_o,
    output logic                    ready_write_o,
    output logic                    ready_read_o,
    output logic [31:0]             data_o,
    output logic                    bk_req_o,
    output logic                    bk_rw_o,
    output logic [BW_WORD_ADDR-1:0] bk_add_o,
    output logic [31:0]             bk_data_o,
    input  logic                    bk_ready_i,
    input  logic                    bk_valid_i,
    input  logic [31:0]             bk_data_i
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = BW_BLOCK + 1;

    typedef enum logic [1:0] {IDLE, WRITE, READ} state_t;

    state_t                  state, state_nx;
    logic [BW_WORD_ADDR-1:0] base;
    logic [CW-1:0]           len, accepted, issued, delivered;
    logic [AW:0]             count, outstanding;
    logic [AW-1:0]           wr_ptr, rd_ptr;
    logic [31:0]             fifo_mem [FIFO_DEPTH];
    logic [31:0]             head;
    logic                    empty, full, issue, wr_accept, rd_ret, rd_pop, push, pop, wr_done, rd_done;

    assign head          = fifo_mem[rd_ptr];
    assign empty         = count == '0;
    assign full          = count == (AW+1)'(FIFO_DEPTH);
    assign ready_req_o   = state == IDLE;
    assign ready_write_o = state == WRITE && accepted < len && !full;
    assign ready_read_o  = state == READ && !empty;
    assign data_o        = empty ? '0 : head;
    assign bk_req_o      = state == WRITE ? !empty
                         : state == READ && issued < len
                           && (AW+2)'(count) + (AW+2)'(outstanding) < (AW+2)'(FIFO_DEPTH);
    assign bk_rw_o       = state == WRITE;
    assign bk_add_o      = bk_req_o ? base + BW_WORD_ADDR'(issued) : '0;
    assign bk_data_o     = state == WRITE && !empty ? head : '0;
    assign issue         = bk_req_o & bk_ready_i;
    assign wr_accept     = write_i & ready_write_o;
    assign rd_ret        = state == READ && bk_valid_i && outstanding != '0;
    assign rd_pop        = read_i & ready_read_o;
    assign push          = wr_accept | rd_ret;
    assign pop           = (state == WRITE & issue) | rd_pop;
    assign wr_done       = state == WRITE && issue && issued == len - CW'(1);
    assign rd_done       = rd_pop && delivered == len - CW'(1);

    // state register
    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) state <= IDLE;
        else         state <= state_nx;
    end

    // next state: capture command in IDLE, return once the last word is issued or delivered
    always_comb begin
        state_nx = state;
        if (state == IDLE && req_i) state_nx = rw_i ? WRITE : READ;
        else if (wr_done || rd_done) state_nx = IDLE;
    end

    // command capture and transfer progress counters
    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            base        <= '0;
            len         <= '0;
            accepted    <= '0;
            issued      <= '0;
            delivered   <= '0;
            outstanding <= '0;
        end else if (state == IDLE) begin
            if (req_i) begin
                base        <= req_block_i ? {add_i[BW_WORD_ADDR-1:BW_BLOCK], {BW_BLOCK{1'b0}}} : add_i;
                len         <= req_block_i ? CW'(1 << BW_BLOCK) : CW'(1);
                accepted    <= '0;
                issued      <= '0;
                delivered   <= '0;
                outstanding <= '0;
            end
        end else begin
            if (wr_accept) accepted <= accepted + CW'(1);
            if (issue) issued <= issued + CW'(1);
            if (rd_pop) delivered <= delivered + CW'(1);
            outstanding <= outstanding + (AW+1)'(issue & (state == READ)) - (AW+1)'(rd_ret);
        end
    end

    // fifo pointers and occupancy; simultaneous push and pop leave the count unchanged
    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop) rd_ptr <= rd_ptr + AW'(1);
            count <= count + (AW+1)'(push) - (AW+1)'(pop);
        end
    end

    // fifo storage; contents are don't-care while empty, so no reset is needed
    always_ff @(posedge clock_i) begin
        if (push) fifo_mem[wr_ptr] <= state == WRITE ? data_i : bk_data_i;
    end
endmodule
